mc_phase_ctrl: RTL and testbench
================================

Name: mc_phase_ctrl

Overview:
Parametrised multicycle processor phase controller. It sequences IF/ID/EXE/MEM/WB per instruction and skips phases by instruction class. IF and MEM stall on a memory ready handshake, with a bounded-wait fault. It also keeps retired-instruction and active-cycle counters. It sits between the datapath control decoder and the memory interface, and drives the one-hot phase enables to the datapath.

Parameters:
CNT_WIDTH, 16, width of instr_count and cycle_count (wrap modulo 2^CNT_WIDTH)
MEM_WAIT_MAX, 15, max not-ready cycles tolerated in IF/MEM before FAULT; 0 disables the timeout
WAIT_WIDTH, 4, width of the internal wait counter; must hold MEM_WAIT_MAX

Ports:
clk  input  1  system clock, rising edge
reset  input  1  one clock; reset is asynchronous and active-high
enable  input  1  advance permission; 0 freezes the FSM and all counters
op_class  input  2  instruction class, sampled in ID: 00 ALU, 01 LOAD, 10 STORE, 11 BRANCH
mem_ready  input  1  memory completion for the current IF/MEM request
mem_req  output  1  memory request, =1 in IF or MEM (combinational from state)
stateIF  output  1  one-hot phase: fetch
stateID  output  1  one-hot phase: decode
stateEXE  output  1  one-hot phase: execute
stateMEM  output  1  one-hot phase: memory
stateWB  output  1  one-hot phase: writeback
retire  output  1  combinational strobe, =1 in the cycle whose edge completes an instruction
fault  output  1  =1 while in FAULT
instr_count  output  CNT_WIDTH  retired instruction count
cycle_count  output  CNT_WIDTH  enabled cycles spent in IF..WB

Behaviour:
- States: RESET, IF, ID, EXE, MEM, WB, FAULT. Registered state; outputs decode combinationally from state.
- Async reset (any time, including mid-MEM wait) forces:
  - state=RESET, op_class latch=00, wait_cnt=0, instr_count=0, cycle_count=0.
  - All phase outputs, mem_req and fault read 0 in RESET.
- When enable=0:
  - State, latched class, wait_cnt and both counters hold.
  - mem_ready is ignored; retire=0.
  - Phase outputs and mem_req still reflect the held state.
- Transitions, evaluated only when enable=1, on the rising edge:
  - RESET -> IF.
  - IF: mem_ready=1 -> ID. If mem_ready=0 and timeout condition -> FAULT. Otherwise stay and wait_cnt+1.
  - ID -> EXE; op_class latched on this edge.
  - EXE by latched class: ALU -> WB; LOAD -> MEM; STORE -> MEM; BRANCH -> IF (retire).
  - MEM: on mem_ready=1, LOAD -> WB and STORE -> IF (retire). If mem_ready=0, timeout/stay rule as in IF.
  - WB -> IF (retire).
  - FAULT: absorbing; exits only via reset. No phase output set, mem_req=0, fault=1.
- Timeout condition: MEM_WAIT_MAX!=0 and wait_cnt==MEM_WAIT_MAX.
  - mem_ready arriving on the (MEM_WAIT_MAX+1)th cycle in IF/MEM is still accepted.
  - wait_cnt clears to 0 on every edge entering IF or MEM.
- Simultaneous mem_ready=1 and timeout condition: ready wins; no FAULT.
- retire = enable & ((EXE & BRANCH) | (MEM & STORE & mem_ready) | WB).
- instr_count increments on the same edge that retire is sampled high.
- cycle_count increments on each enabled edge while in IF, ID, EXE, MEM or WB.
- Latencies with mem_ready tied 1, counted in phase cycles from entry into IF: ALU 4, LOAD 5, STORE 4, BRANCH 3. Each not-ready cycle adds 1.
- Exactly one phase output is high in IF..WB; none in RESET or FAULT.

Test Plan:
1. ALU sequence: reset pulse, enable=1, mem_ready=1, op_class=00. Required: phases IF,ID,EXE,WB,IF; retire high only in the WB cycle; instr_count=1 and cycle_count=4 after the WB edge.
2. LOAD with stall: op_class=01, mem_ready=0 for 3 MEM cycles then 1. Required: MEM held 4 cycles with mem_req=1, then WB, then IF; instr_count=1, cycle_count=8.
3. STORE and BRANCH: STORE (10) goes EXE->MEM->IF with retire in MEM and no WB. Then BRANCH (11) goes EXE->IF with retire in EXE. Required: instr_count=2.
4. Timeout: MEM_WAIT_MAX=15, mem_ready=0 forever in IF. Required: FAULT entered on the 16th IF edge; fault=1, mem_req=0, all phase outputs 0; stays there until reset. Repeat with ready on the 16th cycle: required ID, no fault.
5. Freeze: deassert enable in MEM with mem_ready=1. Required: state, counters and wait_cnt held; retire=0 throughout. Reassert enable: required advance on the next edge.
6. Async reset mid-MEM wait (wait_cnt=5, counts nonzero). Required: outputs cleared immediately without a clock edge; after release, RESET->IF with fresh counts 0.

Source files
------------

// File: rtl/mc_phase_ctrl.sv
// Multicycle processor phase controller: sequences IF/ID/EXE/MEM/WB per
// instruction, skips phases by class, bounds memory waits, counts activity.
module mc_phase_ctrl #(
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned WAIT_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           op_class,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 stateIF,
  output logic                 stateID,
  output logic                 stateEXE,
  output logic                 stateMEM,
  output logic                 stateWB,
  output logic                 retire,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam logic [1:0] CLS_ALU    = 2'b00;
  localparam logic [1:0] CLS_LOAD   = 2'b01;
  localparam logic [1:0] CLS_STORE  = 2'b10;
  localparam logic [1:0] CLS_BRANCH = 2'b11;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_IF    = 3'd1,
    S_ID    = 3'd2,
    S_EXE   = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t                r_state;
  logic [1:0]            r_class;
  logic [WAIT_WIDTH-1:0] r_wait;
  logic [CNT_WIDTH-1:0]  r_instr;
  logic [CNT_WIDTH-1:0]  r_cycle;

  logic w_timeout;
  logic w_active;
  logic w_retire;

  // A zero limit disables the bounded wait entirely.
  assign w_timeout = (MEM_WAIT_MAX != 0) && (r_wait == WAIT_WIDTH'(MEM_WAIT_MAX));

  assign w_active = (r_state == S_IF)  || (r_state == S_ID) || (r_state == S_EXE) ||
                    (r_state == S_MEM) || (r_state == S_WB);

  assign w_retire = enable &
                    (((r_state == S_EXE) && (r_class == CLS_BRANCH)) ||
                     ((r_state == S_MEM) && (r_class == CLS_STORE) && mem_ready) ||
                     (r_state == S_WB));

  // Phase decode straight from the state register.
  assign stateIF     = (r_state == S_IF);
  assign stateID     = (r_state == S_ID);
  assign stateEXE    = (r_state == S_EXE);
  assign stateMEM    = (r_state == S_MEM);
  assign stateWB     = (r_state == S_WB);
  assign mem_req     = (r_state == S_IF) || (r_state == S_MEM);
  assign fault       = (r_state == S_FAULT);
  assign retire      = w_retire;
  assign instr_count = r_instr;
  assign cycle_count = r_cycle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RESET;
      r_class <= CLS_ALU;
      r_wait  <= '0;
      r_instr <= '0;
      r_cycle <= '0;
    end else if (enable) begin
      if (w_retire) r_instr <= r_instr + CNT_WIDTH'(1);
      if (w_active) r_cycle <= r_cycle + CNT_WIDTH'(1);

      case (r_state)
        S_RESET: begin
          r_state <= S_IF;
          r_wait  <= '0;
        end
        S_IF: begin
          if (mem_ready)      r_state <= S_ID;
          else if (w_timeout) r_state <= S_FAULT;
          else                r_wait  <= r_wait + WAIT_WIDTH'(1);
        end
        S_ID: begin
          r_state <= S_EXE;
          r_class <= op_class;
        end
        S_EXE: begin
          r_wait <= '0;
          case (r_class)
            CLS_ALU:             r_state <= S_WB;
            CLS_LOAD, CLS_STORE: r_state <= S_MEM;
            default:             r_state <= S_IF;
          endcase
        end
        S_MEM: begin
          // Ready takes priority over an expiring wait on the same edge.
          if (mem_ready) begin
            if (r_class == CLS_LOAD) begin
              r_state <= S_WB;
            end else begin
              r_state <= S_IF;
              r_wait  <= '0;
            end
          end else if (w_timeout) begin
            r_state <= S_FAULT;
          end else begin
            r_wait <= r_wait + WAIT_WIDTH'(1);
          end
        end
        S_WB: begin
          r_state <= S_IF;
          r_wait  <= '0;
        end
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_phase_ctrl.sv
// Scoreboard bench for mc_phase_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_phase_ctrl;

  localparam int P_RST = 0;
  localparam int P_IF  = 1;
  localparam int P_ID  = 2;
  localparam int P_EXE = 3;
  localparam int P_MEM = 4;
  localparam int P_WB  = 5;
  localparam int P_FLT = 6;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  op_class;
  logic        mem_ready;
  logic        mem_req;
  logic        stateIF, stateID, stateEXE, stateMEM, stateWB;
  logic        retire;
  logic        fault;
  logic [15:0] instr_count;
  logic [15:0] cycle_count;

  mc_phase_ctrl #(.CNT_WIDTH(16), .MEM_WAIT_MAX(15), .WAIT_WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .op_class   (op_class),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .stateIF    (stateIF),
    .stateID    (stateID),
    .stateEXE   (stateEXE),
    .stateMEM   (stateMEM),
    .stateWB    (stateWB),
    .retire     (retire),
    .fault      (fault),
    .instr_count(instr_count),
    .cycle_count(cycle_count)
  );

  typedef struct {
    int   tid;
    int   idx;
    int   ph;
    logic ret;
    int   ic;
    int   cc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cur_tid = 0;
  int   cur_idx = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int tid, input int idx, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL t%0d c%0d %s: got %0d expected %0d", tid, idx, name, act, exp);
    end
  endtask

  function automatic int onehot_of(input int ph);
    case (ph)
      P_IF:    return 5'b10000;
      P_ID:    return 5'b01000;
      P_EXE:   return 5'b00100;
      P_MEM:   return 5'b00010;
      P_WB:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  // Monitor: one queued expectation per clock, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("phase", e.tid, e.idx, 32'({stateIF, stateID, stateEXE, stateMEM, stateWB}), onehot_of(e.ph));
      chk("mem_req", e.tid, e.idx, 32'(mem_req), ((e.ph == P_IF) || (e.ph == P_MEM)) ? 1 : 0);
      chk("fault", e.tid, e.idx, 32'(fault), (e.ph == P_FLT) ? 1 : 0);
      chk("retire", e.tid, e.idx, 32'(retire), 32'(e.ret));
      chk("instr_count", e.tid, e.idx, 32'(instr_count), e.ic);
      chk("cycle_count", e.tid, e.idx, 32'(cycle_count), e.cc);
    end
  end

  task automatic step(input logic en, input logic [1:0] cls, input logic rdy,
                      input int ph, input logic ret, input int ic, input int cc);
    exp_t e;
    @(posedge clk);
    #1;
    enable    = en;
    op_class  = cls;
    mem_ready = rdy;
    e.tid = cur_tid;
    e.idx = cur_idx;
    e.ph  = ph;
    e.ret = ret;
    e.ic  = ic;
    e.cc  = cc;
    exp_q.push_back(e);
    cur_idx++;
  endtask

  task automatic do_reset(input int tid);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    cur_tid = tid;
    cur_idx = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    op_class  = 2'b00;
    mem_ready = 1'b0;

    // 1: ALU, ready tied high
    do_reset(1);
    step(1, 2'b00, 1, P_RST, 0, 0, 0);
    step(1, 2'b00, 1, P_IF,  0, 0, 0);
    step(1, 2'b00, 1, P_ID,  0, 0, 1);
    step(1, 2'b11, 1, P_EXE, 0, 0, 2);
    step(1, 2'b00, 1, P_WB,  1, 0, 3);
    step(0, 2'b00, 1, P_IF,  0, 1, 4);

    // 2: LOAD with three not-ready MEM cycles
    do_reset(2);
    step(1, 2'b00, 1, P_RST, 0, 0, 0);
    step(1, 2'b00, 1, P_IF,  0, 0, 0);
    step(1, 2'b01, 1, P_ID,  0, 0, 1);
    step(1, 2'b00, 1, P_EXE, 0, 0, 2);
    step(1, 2'b00, 0, P_MEM, 0, 0, 3);
    step(1, 2'b00, 0, P_MEM, 0, 0, 4);
    step(1, 2'b00, 0, P_MEM, 0, 0, 5);
    step(1, 2'b00, 1, P_MEM, 0, 0, 6);
    step(1, 2'b00, 1, P_WB,  1, 0, 7);
    step(0, 2'b00, 1, P_IF,  0, 1, 8);

    // 3: STORE then BRANCH; class changes outside ID must be ignored
    do_reset(3);
    step(1, 2'b00, 1, P_RST, 0, 0, 0);
    step(1, 2'b00, 1, P_IF,  0, 0, 0);
    step(1, 2'b10, 1, P_ID,  0, 0, 1);
    step(1, 2'b00, 1, P_EXE, 0, 0, 2);
    step(1, 2'b01, 1, P_MEM, 1, 0, 3);
    step(1, 2'b00, 1, P_IF,  0, 1, 4);
    step(1, 2'b11, 1, P_ID,  0, 1, 5);
    step(1, 2'b00, 1, P_EXE, 1, 1, 6);
    step(0, 2'b00, 1, P_IF,  0, 2, 7);

    // 4a: IF never ready -> FAULT on the 16th IF edge, absorbing
    do_reset(4);
    step(1, 2'b00, 0, P_RST, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 2'b00, 0, P_IF, 0, 0, i);
    step(1, 2'b00, 1, P_FLT, 0, 0, 16);
    step(1, 2'b11, 1, P_FLT, 0, 0, 16);
    step(0, 2'b00, 0, P_FLT, 0, 0, 16);

    // 4b: ready on the 16th IF cycle is still accepted
    do_reset(5);
    step(1, 2'b00, 0, P_RST, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 2'b00, 0, P_IF, 0, 0, i);
    step(1, 2'b00, 1, P_IF, 0, 0, 15);
    step(0, 2'b00, 1, P_ID, 0, 0, 16);

    // 5a: freeze in MEM with ready high on a STORE
    do_reset(6);
    step(1, 2'b00, 1, P_RST, 0, 0, 0);
    step(1, 2'b00, 1, P_IF,  0, 0, 0);
    step(1, 2'b10, 1, P_ID,  0, 0, 1);
    step(1, 2'b00, 1, P_EXE, 0, 0, 2);
    step(1, 2'b00, 0, P_MEM, 0, 0, 3);
    step(0, 2'b00, 1, P_MEM, 0, 0, 4);
    step(0, 2'b00, 1, P_MEM, 0, 0, 4);
    step(1, 2'b00, 1, P_MEM, 1, 0, 4);
    step(0, 2'b00, 1, P_IF,  0, 1, 5);

    // 5b: frozen cycles must not advance the wait counter
    do_reset(7);
    step(1, 2'b00, 0, P_RST, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 2'b00, 0, P_IF, 0, 0, i);
    for (int i = 0; i < 4; i++)  step(0, 2'b00, 0, P_IF, 0, 0, 10);
    for (int i = 0; i < 6; i++)  step(1, 2'b00, 0, P_IF, 0, 0, 10 + i);
    step(0, 2'b00, 0, P_FLT, 0, 0, 16);

    // 6: async reset during a MEM wait with wait_cnt at 5
    do_reset(8);
    step(1, 2'b00, 1, P_RST, 0, 0, 0);
    step(1, 2'b00, 1, P_IF,  0, 0, 0);
    step(1, 2'b00, 1, P_ID,  0, 0, 1);
    step(1, 2'b00, 1, P_EXE, 0, 0, 2);
    step(1, 2'b00, 1, P_WB,  1, 0, 3);
    step(1, 2'b00, 1, P_IF,  0, 1, 4);
    step(1, 2'b01, 1, P_ID,  0, 1, 5);
    step(1, 2'b00, 1, P_EXE, 0, 1, 6);
    for (int i = 0; i < 5; i++) step(1, 2'b00, 0, P_MEM, 0, 1, 7 + i);
    @(posedge clk);
    #1;
    chk("pre_reset_mem", 8, 100, 32'(stateMEM), 1);
    chk("pre_reset_cc", 8, 100, 32'(cycle_count), 12);
    #2;
    reset = 1'b1;
    #1;
    chk("async_phase", 8, 101, 32'({stateIF, stateID, stateEXE, stateMEM, stateWB}), 0);
    chk("async_mem_req", 8, 101, 32'(mem_req), 0);
    chk("async_fault", 8, 101, 32'(fault), 0);
    chk("async_ic", 8, 101, 32'(instr_count), 0);
    chk("async_cc", 8, 101, 32'(cycle_count), 0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    enable  = 1'b0;
    cur_tid = 9;
    cur_idx = 0;
    step(1, 2'b00, 1, P_RST, 0, 0, 0);
    step(1, 2'b00, 1, P_IF,  0, 0, 0);
    step(0, 2'b00, 1, P_ID,  0, 0, 1);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
